// File: rtl/output_framebuffer_ram.sv
// output_framebuffer_ram: simple-dual-port pixel buffer with byte enables, 1/2-stage read pipe,
// defined collision behaviour and a hardware clear sweep.
module output_framebuffer_ram #(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    ADDR_WIDTH     = 7,
    parameter int                    DEPTH          = 128,
    parameter int                    READ_LATENCY   = 1,
    parameter int                    COLLISION_MODE = 0,
    parameter int                    CLEAR_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid,
    output logic                    ready,
    input  logic                    clear_req,
    output logic                    clear_busy,
    output logic                    addr_err
);
    localparam int                    NB     = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0]   DEPTH_X = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST   = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic                    p_valid_q, p_err_q;
    logic [DATA_WIDTH-1:0]   p_data_q;
    logic                    rd_valid_q, rd_valid_d;
    logic                    addr_err_q, addr_err_d;
    logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
    logic                    wr_ok, wr_bad, rd_acc, rd_ok, rd_bad, collide;
    logic                    out_v, out_e;
    logic [DATA_WIDTH-1:0]   rd_word, merged, rd_sel, out_d;

    assign ready      = (state_q == IDLE);
    assign clear_busy = (state_q == CLEAR);
    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign addr_err   = addr_err_q;

    assign wr_ok   = wr_en & ready & ({1'b0, wr_addr} < DEPTH_X);
    assign wr_bad  = wr_en & ready & ~({1'b0, wr_addr} < DEPTH_X);
    assign rd_acc  = rd_en & ready;
    assign rd_ok   = rd_acc & ({1'b0, rd_addr} < DEPTH_X);
    assign rd_bad  = rd_acc & ~({1'b0, rd_addr} < DEPTH_X);
    assign collide = (COLLISION_MODE == 1) && wr_ok && (wr_addr == rd_addr);
    assign rd_word = mem[rd_addr];

    // Write-first view of the read word, only used on a same-address collision
    always_comb begin
        merged = rd_word;
        for (int i = 0; i < NB; i++)
            merged[8*i +: 8] = wr_be[i] ? wr_data[8*i +: 8] : rd_word[8*i +: 8];
    end

    assign rd_sel = rd_ok ? (collide ? merged : rd_word) : '0;
    assign out_v  = (READ_LATENCY == 2) ? p_valid_q : rd_acc;
    assign out_d  = (READ_LATENCY == 2) ? p_data_q  : rd_sel;
    assign out_e  = (READ_LATENCY == 2) ? p_err_q   : rd_bad;

    always_comb begin
        rd_valid_d = out_v;
        rd_data_d  = out_v ? out_d : rd_data_q;
        addr_err_d = wr_bad | (out_v & out_e);
        state_d    = state_q;
        ptr_d      = ptr_q;
        if (state_q == IDLE) begin
            state_d = clear_req ? CLEAR : IDLE;
            ptr_d   = '0;
        end else begin
            state_d = (ptr_q == LAST) ? IDLE : CLEAR;
            ptr_d   = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= (CLEAR_ON_RESET == 1) ? CLEAR : IDLE;
            ptr_q      <= '0;
            p_valid_q  <= 1'b0;
            p_err_q    <= 1'b0;
            p_data_q   <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            p_valid_q  <= rd_acc;
            p_err_q    <= rd_bad;
            p_data_q   <= rd_sel;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            addr_err_q <= addr_err_d;
        end
    end

    // Array is never reset; the clear sweep owns the write port while it runs
    always_ff @(posedge clk) begin
        if (n_rst && state_q == CLEAR)
            mem[ptr_q] <= CLEAR_VALUE;
        else if (n_rst && wr_ok)
            for (int i = 0; i < NB; i++)
                if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
    end
endmodule

// File: tb/tb_output_framebuffer_ram.sv
// tb_output_framebuffer_ram: two configurations driven with shared stimulus, each scored
// against an array/queue model of the buffer behaviour.
module tb_output_framebuffer_ram;
    localparam logic [31:0] FILL1 = 32'hA5A5_5A5A;

    typedef struct {
        int          due;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        wr_en = 1'b0, rd_en = 1'b0, clear_req = 1'b0;
    logic [6:0]  wr_addr = '0, rd_addr = '0;
    logic [31:0] wr_data = '0;
    logic [3:0]  wr_be = '0;
    logic [31:0] rd_data [2];
    logic        rd_valid [2], ready [2], clear_busy [2], addr_err [2];

    exp_t        q [2][$];
    logic [31:0] mm [2][128];
    int          busy [2];
    bit          err_exp [2][4];
    logic [31:0] last [2];
    int          vecs = 0, errs = 0, cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    output_framebuffer_ram u0 (
        .clk(clk), .n_rst(n_rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data[0]),
        .rd_valid(rd_valid[0]), .ready(ready[0]), .clear_req(clear_req),
        .clear_busy(clear_busy[0]), .addr_err(addr_err[0])
    );

    output_framebuffer_ram #(
        .DEPTH(100), .READ_LATENCY(2), .COLLISION_MODE(1), .CLEAR_VALUE(FILL1)
    ) u1 (
        .clk(clk), .n_rst(n_rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data[1]),
        .rd_valid(rd_valid[1]), .ready(ready[1]), .clear_req(clear_req),
        .clear_busy(clear_busy[1]), .addr_err(addr_err[1])
    );

    function automatic int dep(input int k);
        return (k == 1) ? 100 : 128;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] req);
        vecs++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s u%0d cyc %0d: got %h expected %h", name, k, cyc, act, req);
        end
    endtask

    // Reference model: advances one clock edge using the inputs about to be sampled
    task automatic model();
        int          d, c, rl;
        bit          wok;
        logic [31:0] rdv;
        exp_t        e;
        c = cyc;
        for (int k = 0; k < 2; k++) begin
            d  = dep(k);
            rl = (k == 1) ? 2 : 1;
            if (busy[k] == 0) begin
                wok = wr_en && int'(wr_addr) < d;
                if (rd_en) begin
                    if (int'(rd_addr) >= d) begin
                        rdv = '0;
                        err_exp[k][(c + rl) % 4] = 1'b1;
                    end else if (k == 1 && wok && wr_addr == rd_addr)
                        rdv = merge(mm[k][rd_addr], wr_data, wr_be);
                    else
                        rdv = mm[k][rd_addr];
                    e.due  = c + rl;
                    e.data = rdv;
                    q[k].push_back(e);
                end
                if (wr_en) begin
                    if (wok) mm[k][wr_addr] = merge(mm[k][wr_addr], wr_data, wr_be);
                    else     err_exp[k][(c + 1) % 4] = 1'b1;
                end
                if (clear_req) busy[k] = d;
            end else begin
                mm[k][d - busy[k]] = (k == 1) ? FILL1 : 32'h0;
                busy[k]--;
            end
        end
    endtask

    task automatic rst_model();
        for (int k = 0; k < 2; k++) begin
            q[k].delete();
            for (int j = 0; j < 4; j++) err_exp[k][j] = 1'b0;
            busy[k] = dep(k);
            last[k] = '0;
        end
    endtask

    task automatic step(input bit we, input logic [6:0] wa, input logic [31:0] wd,
                        input logic [3:0] be, input bit re, input logic [6:0] ra, input bit cr);
        @(negedge clk);
        #2;
        wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
        rd_en = re; rd_addr = ra; clear_req = cr;
        model();
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 7'd0, 32'h0, 4'h0, 1'b0, 7'd0, 1'b0);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        #2;
        wr_en = 1'b0; rd_en = 1'b0; clear_req = 1'b0;
        n_rst = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_rd_valid", k, rd_valid[k], 1'b0);
            chk("rst_rd_data", k, rd_data[k], 32'h0);
            chk("rst_addr_err", k, addr_err[k], 1'b0);
            chk("rst_clear_busy", k, clear_busy[k], 1'b1);
        end
        rst_model();
        @(negedge clk);
        #2;
        n_rst = 1'b1;
        model();
    endtask

    // Monitor: compares every cycle; pops the scoreboard whenever a read result is due
    initial begin
        exp_t e;
        bit   ev;
        forever begin
            @(negedge clk);
            if (n_rst) begin
                for (int k = 0; k < 2; k++) begin
                    ev = (q[k].size() > 0) && (q[k][0].due == cyc);
                    chk("ready", k, ready[k], busy[k] == 0);
                    chk("clear_busy", k, clear_busy[k], busy[k] != 0);
                    chk("rd_valid", k, rd_valid[k], ev);
                    if (ev) begin
                        e = q[k].pop_front();
                        last[k] = e.data;
                    end
                    chk("rd_data", k, rd_data[k], last[k]);
                    chk("addr_err", k, addr_err[k], err_exp[k][cyc % 4]);
                    err_exp[k][cyc % 4] = 1'b0;
                end
            end
        end
    end

    initial begin
        bit         we, re;
        logic [6:0] wa, ra;
        rst_model();
        @(negedge clk);
        #2;
        n_rst = 1'b1;
        model();
        idle(130);
        for (int a = 0; a < 128; a++) step(1'b0, 7'd0, 32'h0, 4'h0, 1'b1, 7'(a), 1'b0);
        idle(3);
        step(1'b1, 7'd5, 32'hDEAD_BEEF, 4'b1111, 1'b0, 7'd0, 1'b0);
        step(1'b1, 7'd5, 32'h1122_3344, 4'b0101, 1'b0, 7'd0, 1'b0);
        step(1'b0, 7'd0, 32'h0, 4'h0, 1'b1, 7'd5, 1'b0);
        step(1'b1, 7'd9, 32'hAAAA_AAAA, 4'b1111, 1'b0, 7'd0, 1'b0);
        step(1'b1, 7'd9, 32'h5555_5555, 4'b1111, 1'b1, 7'd9, 1'b0);
        step(1'b0, 7'd0, 32'h0, 4'h0, 1'b1, 7'd9, 1'b0);
        step(1'b0, 7'd0, 32'h0, 4'h0, 1'b1, 7'd0, 1'b0);
        step(1'b0, 7'd0, 32'h0, 4'h0, 1'b1, 7'd1, 1'b0);
        step(1'b0, 7'd0, 32'h0, 4'h0, 1'b1, 7'd2, 1'b0);
        step(1'b1, 7'd110, 32'h7777_7777, 4'b1111, 1'b1, 7'd120, 1'b0);
        idle(2);
        step(1'b0, 7'd0, 32'h0, 4'h0, 1'b1, 7'd110, 1'b0);
        step(1'b0, 7'd0, 32'h0, 4'h0, 1'b1, 7'd5, 1'b1);
        idle(60);
        reset_pulse();
        idle(135);
        for (int n = 0; n < 1500; n++) begin
            we = 1'($urandom);
            re = 1'($urandom);
            wa = 7'($urandom_range(0, 127));
            ra = ($urandom_range(0, 3) == 0) ? wa : 7'($urandom_range(0, 127));
            step(we, wa, $urandom, 4'($urandom), re, ra, $urandom_range(0, 199) == 0);
        end
        idle(140);
        for (int k = 0; k < 2; k++) chk("drain", k, q[k].size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/output_framebuffer_ram.md
Name: output_framebuffer_ram

Overview:
Parametrised simple-dual-port buffer RAM for the output controller. It stages pixel words between the render path and the display scan-out.
- Adds per-byte write enables and a configurable read pipeline with a valid strobe.
- Defines read/write collision behaviour.
- Includes a hardware clear engine that sweeps the array to a fill value after reset or on request.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of 8
ADDR_WIDTH, 7, address width in bits
DEPTH, 128, number of words; DEPTH <= 2**ADDR_WIDTH
READ_LATENCY, 1, clock edges from accepted read to rd_valid; legal values 1 or 2
COLLISION_MODE, 0, same-address read and write in one cycle: 0 = read returns old word, 1 = read returns newly written word
CLEAR_ON_RESET, 1, 1 = clear sweep starts automatically when reset releases
CLEAR_VALUE, 0, DATA_WIDTH-bit fill word written by the clear engine

Ports:
clk  in  1  system clock; all logic on rising edge
n_rst  in  1  asynchronous active-low reset
wr_en  in  1  write request
wr_addr  in  ADDR_WIDTH  write address
wr_data  in  DATA_WIDTH  write data
wr_be  in  DATA_WIDTH/8  byte enables; bit i covers wr_data[8i+7:8i]
rd_en  in  1  read request
rd_addr  in  ADDR_WIDTH  read address
rd_data  out  DATA_WIDTH  read data
rd_valid  out  1  one-cycle strobe: rd_data holds the result of an accepted read
ready  out  1  high in IDLE; requests are accepted only while ready=1
clear_req  in  1  pulse to start a clear sweep
clear_busy  out  1  high while the clear sweep runs
addr_err  out  1  one-cycle strobe: an accepted access had an address >= DEPTH

Behaviour:
- Reset (n_rst=0, asynchronous):
  - rd_data=0, rd_valid=0, addr_err=0; read pipeline flushed.
  - Clear pointer=0.
  - State=CLEAR if CLEAR_ON_RESET=1, else IDLE; clear_busy and ready follow the state.
  - The memory array itself is not reset.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR: clear_req=1 at a clock edge.
  - CLEAR -> IDLE: on the edge that writes address DEPTH-1.
  - clear_req during CLEAR is ignored (no restart).
- CLEAR sweep:
  - Writes CLEAR_VALUE to the address at the pointer, one word per cycle, addresses 0..DEPTH-1. Sweep takes exactly DEPTH cycles.
  - ready=0 and clear_busy=1 throughout. wr_en/rd_en are ignored: no write, no rd_valid, no addr_err.
  - Reset mid-sweep aborts; the sweep restarts from 0 after release if CLEAR_ON_RESET=1.
- Writes:
  - Accepted when wr_en=1 and ready=1.
  - Only bytes whose wr_be bit is 1 are updated; wr_be=0 leaves the word unchanged.
  - Write is visible to reads accepted on later edges.
- Reads:
  - Accepted when rd_en=1 and ready=1 at edge N.
  - rd_data updates and rd_valid pulses high after edge N+READ_LATENCY-1 (latency 1: valid in the cycle after acceptance).
  - Back-to-back reads are fully pipelined, one per cycle.
  - rd_data holds its last value while rd_valid=0.
- Collision (accepted read and write to the same address in the same cycle):
  - COLLISION_MODE=0: read returns the pre-write word.
  - COLLISION_MODE=1: read returns the merged word (new bytes where wr_be=1, old bytes elsewhere).
- Pipeline drain:
  - Reads in flight when clear_req arrives still complete with their captured data.
  - New reads are blocked once in CLEAR.
- Out-of-range addresses (address >= DEPTH):
  - Write is dropped.
  - Read returns all-zero data with rd_valid=1.
  - addr_err pulses aligned with the write's edge+1 for writes, and with rd_valid for reads.
  - Simultaneous bad read and bad write produce one addr_err pulse per event, ORed where they coincide.
- Address width rule: addresses are unsigned; no wrap-around. Pointer compare is against DEPTH-1.

Test Plan:
1. Reset release with CLEAR_ON_RESET=1, DEPTH=128 -> clear_busy=1 and ready=0 for exactly 128 cycles, then ready=1; a read of every address returns 0x00000000.
2. Write 0xDEADBEEF to addr 5 with be=4'b1111, then write 0x11223344 to addr 5 with be=4'b0101, then read addr 5 (latency 1) -> rd_valid on the next cycle with rd_data=0xDE22BE44.
3. Same-cycle read and write to addr 9 (old word 0xAAAAAAAA, new 0x55555555, be=4'b1111) -> COLLISION_MODE=0 returns 0xAAAAAAAA; COLLISION_MODE=1 returns 0x55555555.
4. READ_LATENCY=2, back-to-back reads of addr 0,1,2 on consecutive edges -> rd_valid high on three consecutive cycles starting two edges after the first read, with data in order.
5. DEPTH=100, read addr 120 and write addr 110 -> rd_data=0 with rd_valid=1, addr_err pulses, write dropped; a later read of addr 110 shows 0.
6. clear_req in IDLE, then n_rst pulsed low at sweep pointer 60 -> rd_valid, rd_data and addr_err go 0 immediately; after release the sweep restarts at 0 and takes 128 cycles.
